draw_rect_engine: RTL

- Parametrised rectangle draw engine, successor to the single-mode square drawer.
- Accepts a rectangle command (origin, size, colour, mode) and walks the pixels in raster order (x inner, y outer). Each pixel is issued to the LT24Display pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady).
- Adds filled/outline modes, clipping to display bounds, zero-size handling, abort, and a start/ready/done handshake.
- Sits between application logic and LT24Display. It owns no LT24 pins.

---
 rtl/draw_pkg.sv | 24 ++
 rtl/rect_clip.sv | 37 +++
 rtl/draw_rect_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle/line/sprite draw engines:
// FSM encoding, draw modes, display defaults and RGB565 colours.
package draw_pkg;

    localparam int LCD_WIDTH_DEF  = 240;
    localparam int LCD_HEIGHT_DEF = 320;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLIP  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

endpackage

// File: rtl/rect_clip.sv
// Combinational rectangle bounds: unclipped last edges, edges clipped to the
// display, and an empty flag for zero-size or fully off-screen rectangles.
module rect_clip
    import draw_pkg::*;
#(
    parameter int LCD_WIDTH  = LCD_WIDTH_DEF,
    parameter int LCD_HEIGHT = LCD_HEIGHT_DEF,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 9
) (
    input  logic [X_BITS-1:0] x_origin,
    input  logic [Y_BITS-1:0] y_origin,
    input  logic [X_BITS-1:0] width,
    input  logic [Y_BITS-1:0] height,
    output logic [X_BITS:0]   x_last,
    output logic [Y_BITS:0]   y_last,
    output logic [X_BITS:0]   x_end,
    output logic [Y_BITS:0]   y_end,
    output logic              empty
);

    localparam logic [X_BITS:0] X_MAX = (X_BITS+1)'(LCD_WIDTH - 1);
    localparam logic [Y_BITS:0] Y_MAX = (Y_BITS+1)'(LCD_HEIGHT - 1);
    localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(LCD_WIDTH);
    localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(LCD_HEIGHT);

    // One extra bit keeps origin+size-1 from wrapping.
    always_comb begin
        x_last = {1'b0, x_origin} + {1'b0, width} - (X_BITS+1)'(1);
        y_last = {1'b0, y_origin} + {1'b0, height} - (Y_BITS+1)'(1);
        x_end  = (x_last > X_MAX) ? X_MAX : x_last;
        y_end  = (y_last > Y_MAX) ? Y_MAX : y_last;
        empty  = (width == '0) || (height == '0) ||
                 ({1'b0, x_origin} >= X_LIM) || ({1'b0, y_origin} >= Y_LIM);
    end

endmodule

// File: rtl/draw_rect_engine.sv
// Rectangle draw engine: walks a clipped filled/outline rectangle in raster
// order and issues one pixel per accepted LT24Display pixel handshake.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | ready=1, waiting for start; command latched on start
//   ST_CLIP  | bounds computed; load first pixel or finish if empty
//   ST_WRITE | pixelWrite=1, advance on acceptance, abort drops pixel
//   ST_DONE  | one-cycle done pulse (aborted qualifies it)
module draw_rect_engine
    import draw_pkg::*;
#(
    parameter int LCD_WIDTH  = LCD_WIDTH_DEF,
    parameter int LCD_HEIGHT = LCD_HEIGHT_DEF,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 9,
    parameter int DATA_BITS  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [X_BITS-1:0]    xOrigin,
    input  logic [Y_BITS-1:0]    yOrigin,
    input  logic [X_BITS-1:0]    width,
    input  logic [Y_BITS-1:0]    height,
    input  logic [DATA_BITS-1:0] colour,
    input  logic                 abort,
    output logic                 ready,
    output logic                 done,
    output logic                 aborted,
    output logic [X_BITS-1:0]    xAddr,
    output logic [Y_BITS-1:0]    yAddr,
    output logic [DATA_BITS-1:0] pixelData,
    output logic                 pixelWrite,
    input  logic                 pixelReady
);

    draw_state_t state, state_nxt;

    logic                 cmd_mode;
    logic [X_BITS-1:0]    cmd_x0, cmd_w;
    logic [Y_BITS-1:0]    cmd_y0, cmd_h;
    logic [DATA_BITS-1:0] cmd_colour;

    logic [X_BITS-1:0]    x_addr;
    logic [Y_BITS-1:0]    y_addr;
    logic [DATA_BITS-1:0] pix_data;
    logic                 aborted_q;

    logic [X_BITS:0] x_last, x_end;
    logic [Y_BITS:0] y_last, y_end;
    logic            clip_empty;

    logic              accept, interior, row_more, y_more;
    logic [X_BITS-1:0] x_step_val;
    logic              load_cmd, load_first, step_x, step_y, end_abort;

    rect_clip #(
        .LCD_WIDTH  (LCD_WIDTH),
        .LCD_HEIGHT (LCD_HEIGHT),
        .X_BITS     (X_BITS),
        .Y_BITS     (Y_BITS)
    ) u_clip (
        .x_origin (cmd_x0),
        .y_origin (cmd_y0),
        .width    (cmd_w),
        .height   (cmd_h),
        .x_last   (x_last),
        .y_last   (y_last),
        .x_end    (x_end),
        .y_end    (y_end),
        .empty    (clip_empty)
    );

    // Outline interior rows only visit the left edge and the right edge,
    // and the right edge is skipped when it lies off-screen.
    always_comb begin
        accept     = (state == ST_WRITE) && pixelReady;
        interior   = (cmd_mode == MODE_OUTLINE) && (y_addr != cmd_y0) &&
                     ({1'b0, y_addr} != y_last);
        row_more   = ({1'b0, x_addr} < x_end) && !(interior && (x_last > x_end));
        y_more     = ({1'b0, y_addr} < y_end);
        x_step_val = interior ? x_last[X_BITS-1:0] : x_addr + X_BITS'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_cmd   = 1'b0;
        load_first = 1'b0;
        step_x     = 1'b0;
        step_y     = 1'b0;
        end_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_cmd  = 1'b1;
                    state_nxt = ST_CLIP;
                end
            end
            ST_CLIP: begin
                if (abort) begin
                    end_abort = 1'b1;
                    state_nxt = ST_DONE;
                end else if (clip_empty) begin
                    state_nxt = ST_DONE;
                end else begin
                    load_first = 1'b1;
                    state_nxt  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    end_abort = 1'b1;
                    state_nxt = ST_DONE;
                end else if (accept) begin
                    if (row_more)    step_x    = 1'b1;
                    else if (y_more) step_y    = 1'b1;
                    else             state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_mode   <= MODE_FILL;
            cmd_x0     <= '0;
            cmd_y0     <= '0;
            cmd_w      <= '0;
            cmd_h      <= '0;
            cmd_colour <= '0;
            x_addr     <= '0;
            y_addr     <= '0;
            pix_data   <= DATA_BITS'(RGB565_BLACK);
            aborted_q  <= 1'b0;
        end else begin
            if (load_cmd) begin
                cmd_mode   <= mode;
                cmd_x0     <= xOrigin;
                cmd_y0     <= yOrigin;
                cmd_w      <= width;
                cmd_h      <= height;
                cmd_colour <= colour;
                aborted_q  <= 1'b0;
            end
            if (end_abort) aborted_q <= 1'b1;
            if (load_first) begin
                x_addr   <= cmd_x0;
                y_addr   <= cmd_y0;
                pix_data <= cmd_colour;
            end
            if (step_x) x_addr <= x_step_val;
            if (step_y) begin
                x_addr <= cmd_x0;
                y_addr <= y_addr + Y_BITS'(1);
            end
        end
    end

    assign ready      = (state == ST_IDLE);
    assign done       = (state == ST_DONE);
    assign aborted    = aborted_q && (state == ST_DONE);
    assign pixelWrite = (state == ST_WRITE);
    assign xAddr      = x_addr;
    assign yAddr      = y_addr;
    assign pixelData  = pix_data;

endmodule
